// File: rtl/bnn_spi_frontend_pkg.sv
// Shared types and constants for the BNN SPI front end: frame/result widths,
// FSM state encoding, feature and result-byte field offsets.
package bnn_spi_frontend_pkg;

    localparam int FEAT_W  = 16;
    localparam int RES_W   = 8;
    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 5;   // bit counter, saturates at 31
    localparam int TMR_W   = 8;   // wide enough to reach TIMEOUT

    // Feature frame field offsets (4 bits each)
    localparam int FEAT_FIELD_W = 4;
    localparam int HEIGHT_LSB   = 12;
    localparam int COLOR_LSB    = 8;
    localparam int WIDTH_LSB    = 4;
    localparam int STEM_LSB     = 0;

    // Result byte field offsets: {hidden[3:0], ok, class[2:0]}
    localparam int OK_BIT  = 3;
    localparam int CLS_LSB = 0;
    localparam int HID_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_e;

    // Assemble the result byte returned to the host
    function automatic logic [RES_W-1:0] pack_result(input logic [3:0] hid,
                                                     input logic       ok,
                                                     input logic [2:0] cls);
        logic [RES_W-1:0] r;
        r                = '0;
        r[HID_LSB +: 4]  = hid;
        r[OK_BIT]        = ok;
        r[CLS_LSB +: 3]  = cls;
        return r;
    endfunction

endpackage

// File: rtl/bnn_spi_frontend_if.sv
// Feature/result handshake between the SPI front end (master) and the
// classifier core (slave).
interface bnn_spi_frontend_if;
    import bnn_spi_frontend_pkg::*;

    logic              feat_valid;
    logic [FEAT_W-1:0] feat_data;
    logic              cls_done;
    logic [2:0]        cls_result;
    logic [3:0]        cls_hidden;

    modport master (
        output feat_valid, feat_data,
        input  cls_done, cls_result, cls_hidden
    );

    modport slave (
        input  feat_valid, feat_data,
        output cls_done, cls_result, cls_hidden
    );
endinterface

// File: rtl/bnn_spi_frontend_sync2.sv
// Two-flop synchroniser for an asynchronous input, with selectable reset value.
module bnn_spi_frontend_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;

    // Shift the async input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];
endmodule

// File: rtl/bnn_spi_frontend.sv
// SPI mode-0 slave front end: receives a 16-bit feature frame, hands it to the
// classifier with a valid/done handshake, captures the result byte and shifts
// it back to the host during the following frame.
module bnn_spi_frontend
    import bnn_spi_frontend_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 busy,
    output logic                 err,
    bnn_spi_frontend_if.master   cls
);
    logic sclk_s, cs_n_s, mosi_s;

    bnn_spi_frontend_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    bnn_spi_frontend_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));
    bnn_spi_frontend_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

    state_e            state_q, state_d;
    logic              sclk_prev_q, cs_n_prev_q;
    logic [FEAT_W-1:0] rx_shift_q, rx_shift_d;
    logic [RES_W-1:0]  tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [FEAT_W-1:0] feat_data_q, feat_data_d;
    logic              feat_valid_q, feat_valid_d;
    logic              miso_q, miso_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    // Edge detectors track the synchronised lines even while ena is low
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_n_s & cs_n_prev_q;
    assign cs_rise   = cs_n_s & ~cs_n_prev_q;

    // What the receive path looks like once this cycle's sclk rise is counted,
    // so a simultaneous cs_n rise sees the final bit before the length check
    logic [FEAT_W-1:0] rx_upd;
    logic [CNT_W-1:0]  cnt_upd;
    assign rx_upd  = sclk_rise ? {rx_shift_q[FEAT_W-2:0], mosi_s} : rx_shift_q;
    assign cnt_upd = (sclk_rise && (bit_cnt_q != {CNT_W{1'b1}})) ? bit_cnt_q + 1'b1 : bit_cnt_q;

    // Next-state logic for the frame FSM, shifters and counters
    always_comb begin
        state_d      = state_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        result_d     = result_q;
        feat_data_d  = feat_data_q;
        feat_valid_d = feat_valid_q;
        miso_d       = miso_q;
        err_d        = err_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d    = RECV;
                        tx_shift_d = result_q;
                        bit_cnt_d  = '0;
                        miso_d     = result_q[RES_W-1];
                    end
                end
                RECV: begin
                    rx_shift_d = rx_upd;
                    bit_cnt_d  = cnt_upd;
                    if (sclk_fall) begin
                        // Zero fill makes miso drop to 0 once the result byte is out
                        tx_shift_d = {tx_shift_q[RES_W-2:0], 1'b0};
                        miso_d     = tx_shift_q[RES_W-2];
                    end
                    if (cs_rise) begin
                        miso_d = 1'b0;
                        if (cnt_upd == CNT_W'(FEAT_W)) begin
                            feat_data_d = rx_upd;
                            err_d       = 1'b0;
                            state_d     = ISSUE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                ISSUE: begin
                    feat_valid_d = 1'b1;
                    timer_d      = '0;
                    state_d      = WAIT;
                    if (cs_fall) err_d = 1'b1;
                end
                WAIT: begin
                    // done takes priority over an expiring timer
                    if (cls.cls_done) begin
                        result_d     = pack_result(cls.cls_hidden, 1'b1, cls.cls_result);
                        feat_valid_d = 1'b0;
                        state_d      = IDLE;
                    end else if (timer_q == TMR_W'(TIMEOUT)) begin
                        result_d     = pack_result(4'h0, 1'b0, 3'h0);
                        err_d        = 1'b1;
                        feat_valid_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                    // A new frame while busy is ignored but flagged
                    if (cs_fall) err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sclk_prev_q  <= 1'b0;
            cs_n_prev_q  <= 1'b1;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            result_q     <= '0;
            feat_data_q  <= '0;
            feat_valid_q <= 1'b0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_prev_q  <= sclk_s;
            cs_n_prev_q  <= cs_n_s;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            result_q     <= result_d;
            feat_data_q  <= feat_data_d;
            feat_valid_q <= feat_valid_d;
            miso_q       <= miso_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign miso           = miso_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign cls.feat_valid = feat_valid_q;
    assign cls.feat_data  = feat_data_q;
endmodule

// File: tb/tb_bnn_spi_frontend.sv
// Self-checking bench for the BNN SPI front end: directed corner cases plus
// randomised frames against a frame-level model of the host-visible behaviour.
module tb_bnn_spi_frontend;
    import bnn_spi_frontend_pkg::*;

    localparam int HALF = 6;   // clk cycles per sclk half period

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b1;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso, busy, err;

    bnn_spi_frontend_if cif();

    bnn_spi_frontend dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .busy(busy), .err(err), .cls(cif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model of what the host and classifier should observe
    logic [15:0] exp_feat   = '0;
    logic [7:0]  exp_result = '0;
    logic        exp_err    = 1'b0;
    int          exp_pulses = 0;
    int          pulses     = 0;

    // Classifier responder configuration (delay < 0: never answer)
    int          resp_delay = 0;
    logic [2:0]  resp_cls   = '0;
    logic [3:0]  resp_hid   = '0;

    initial begin
        cif.cls_done   = 1'b0;
        cif.cls_result = '0;
        cif.cls_hidden = '0;
    end

    // Per-cycle compare: presented features and busy while feat_valid is up
    logic fv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && cif.feat_valid) begin
            check("feat_data_while_valid", 32'(cif.feat_data), 32'(exp_feat));
            check("busy_while_valid", 32'(busy), 32'd1);
        end
        if (cif.feat_valid && !fv_prev) pulses++;
        fv_prev = cif.feat_valid;
    end

    // Classifier responder; updates the expected result byte
    initial begin
        forever begin
            @(negedge clk);
            if (cif.feat_valid) begin
                int n;
                if (resp_delay >= 0) begin
                    repeat (resp_delay) @(negedge clk);
                    cif.cls_result = resp_cls;
                    cif.cls_hidden = resp_hid;
                    cif.cls_done   = 1'b1;
                    if (rst_n) exp_result = {resp_hid, 1'b1, resp_cls};
                end
                n = 0;
                while (cif.feat_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 400) check("feat_valid_falls", 32'(cif.feat_valid), 32'd0);
                cif.cls_done = 1'b0;
                if (resp_delay < 0 && rst_n) begin
                    check("timeout_length_in_range", 32'(n >= TIMEOUT && n <= TIMEOUT + 2), 32'd1);
                    exp_result = 8'h00;
                    exp_err    = 1'b1;
                end
            end
        end
    end

    // Drive one SPI mode-0 frame of nbits, MSB first; returns the last 16 miso bits
    task automatic spi_frame(input logic [31:0] data, input int nbits, input int pause_at,
                             output logic [15:0] rx);
        rx = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits-1-i];
            repeat (HALF) @(negedge clk);
            if (i == pause_at) begin
                ena = 1'b0;
                repeat (10) @(negedge clk);
                ena = 1'b1;
            end
            rx   = {rx[14:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check("busy_clears", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // One complete host transaction checked against the model
    task automatic do_frame(input logic [31:0] data, input int nbits, input int pause_at,
                            input int delay, input logic [2:0] c, input logic [3:0] h,
                            output logic [15:0] rx);
        logic [31:0] seq;
        logic [31:0] mask;
        logic [31:0] exp_rx;
        resp_delay = delay;
        resp_cls   = c;
        resp_hid   = h;
        seq  = {exp_result, 24'h0};
        mask = (nbits >= 16) ? 32'hFFFF : ((32'd1 << nbits) - 32'd1);
        exp_rx = (seq >> (32 - nbits)) & mask;
        if (nbits == 16) exp_feat = data[15:0];
        spi_frame(data, nbits, pause_at, rx);
        if (nbits > 0) check("miso_word", 32'(rx) & mask, exp_rx);
        if (nbits == 16) begin
            exp_pulses++;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        wait_idle();
        check("feat_valid_pulses", 32'(pulses), 32'(exp_pulses));
        check("err", 32'(err), 32'(exp_err));
        check("feat_data_held", 32'(cif.feat_data), 32'(exp_feat));
        $display("[TB] frame data=0x%0h bits=%0d miso=0x%0h err=%0b feat=0x%0h",
                 data, nbits, rx, err, cif.feat_data);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] rx;
        int n;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_feat_valid", 32'(cif.feat_valid), 32'd0);
        check("rst_feat_data", 32'(cif.feat_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reference frame: result must read back as 0xAD
        do_frame(32'hA5C3, 16, -1, 3, 3'd5, 4'hA, rx);
        check("lit_feat_A5C3", 32'(cif.feat_data), 32'hA5C3);
        check("lit_err_after_good", 32'(err), 32'd0);
        do_frame(32'h0F0F, 16, -1, 2, 3'd1, 4'h2, rx);
        check("lit_miso_AD", 32'(rx), 32'hAD00);

        // Bad lengths: 12, 0 and 17 bits, then a good frame clears err
        do_frame(32'h0ABC, 12, -1, 0, 3'd0, 4'h0, rx);
        check("lit_err_12bit", 32'(err), 32'd1);
        do_frame(32'h0, 0, -1, 0, 3'd0, 4'h0, rx);
        do_frame(32'h1_5555, 17, -1, 0, 3'd0, 4'h0, rx);
        do_frame(32'h3C3C, 16, -1, 5, 3'd3, 4'h6, rx);
        check("lit_err_cleared", 32'(err), 32'd0);

        // Classifier never answers
        do_frame(32'h7777, 16, -1, -1, 3'd0, 4'h0, rx);
        check("lit_err_timeout", 32'(err), 32'd1);
        do_frame(32'h1111, 16, -1, 1, 3'd7, 4'h7, rx);
        check("lit_miso_after_timeout", 32'(rx), 32'h0000);

        // Overrun: a second frame while the first is still in WAIT
        resp_delay = 40; resp_cls = 3'd2; resp_hid = 4'h7;
        exp_feat = 16'h1234;
        spi_frame(32'h1234, 16, -1, rx);
        check("overrun_first_miso", 32'(rx), {16'h0, exp_result, 8'h00});
        exp_pulses++;
        spi_frame(32'hFFFF, 16, -1, rx);
        check("overrun_miso_zero", 32'(rx), 32'h0000);
        exp_err = 1'b1;
        wait_idle();
        check("overrun_err", 32'(err), 32'd1);
        check("overrun_pulses", 32'(pulses), 32'(exp_pulses));
        $display("[TB] overrun frame ignored err=%0b", err);
        do_frame(32'h4321, 16, -1, 4, 3'd6, 4'h1, rx);
        check("lit_miso_after_overrun", 32'(rx), 32'h7A00);

        // Reset while waiting on the classifier
        resp_delay = -1;
        exp_feat = 16'hBEEF;
        spi_frame(32'hBEEF, 16, -1, rx);
        exp_pulses++;
        n = 0;
        while (pulses != exp_pulses && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_reached", 32'(pulses), 32'(exp_pulses));
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstwait_feat_valid", 32'(cif.feat_valid), 32'd0);
        check("rstwait_busy", 32'(busy), 32'd0);
        check("rstwait_err", 32'(err), 32'd0);
        check("rstwait_miso", 32'(miso), 32'd0);
        exp_result = 8'h00;
        exp_err    = 1'b0;
        exp_feat   = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] reset during WAIT busy=%0b err=%0b", busy, err);
        do_frame(32'h2468, 16, -1, 2, 3'd4, 4'h9, rx);
        check("lit_miso_after_reset", 32'(rx), 32'h0000);

        // ena held low mid-frame with sclk idle
        do_frame(32'h9ABC, 16, 5, 3, 3'd2, 4'h3, rx);
        check("lit_miso_ena_prev", 32'(rx), 32'h9C00);
        check("lit_feat_ena", 32'(cif.feat_data), 32'h9ABC);

        // Randomised frames
        for (int k = 0; k < 20; k++) begin
            int nb, dly;
            nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : 16;
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
            do_frame({$urandom()} & 32'hF_FFFF, nb, -1, dly,
                     3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), rx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
